// File: rtl/rshifter32_unit.sv
// rshifter32_unit: registered right-shift unit for the ALU32 datapath.
// Barrel shifter (log2(WIDTH) stages) followed by a single output register.
// Logical (Mode=00) and arithmetic (Mode=01) right shifts; Mode=11 acts as logical.
// Optional macro RSHIFTER_ROTATE_EN: Mode=10 becomes rotate right by In2[SW-1:0];
// without it Mode=10 acts as a logical shift and no rotate logic is built.
module rshifter32_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [1:0]       Mode,
    input  logic             In_valid,
    output logic [WIDTH-1:0] Out,
    output logic             Out_valid
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic             w_arith;
    logic             w_fill;
    logic [WIDTH-1:0] w_fill_word;
    logic             w_oversize;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_result;
`ifdef RSHIFTER_ROTATE_EN
    logic             w_rot;
`endif

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    // Mode decode; only 01 is arithmetic, everything else that is not rotate is logical.
    assign w_arith     = (Mode == 2'b01);
    assign w_fill      = w_arith & In1[WIDTH-1];
    assign w_fill_word = {WIDTH{w_fill}};
`ifdef RSHIFTER_ROTATE_EN
    assign w_rot       = (Mode == 2'b10);
`endif

    // Any shift-amount bit above the barrel index means the amount is >= WIDTH.
    assign w_oversize  = |In2[WIDTH-1:SW];

    // Barrel stages: stage k moves the word right by 2^k when In2[k] is set.
    always_comb begin
        logic [WIDTH-1:0] v_ins;
        v_ins   = w_fill_word;
        w_shift = In1;
        for (int unsigned k = 0; k < SW; k++) begin
`ifdef RSHIFTER_ROTATE_EN
            // Rotate feeds the bits falling off the LSB end back in at the top.
            v_ins = w_rot ? w_shift : w_fill_word;
`else
            v_ins = w_fill_word;
`endif
            if (In2[k]) begin
                w_shift = (w_shift >> (1 << k)) | (v_ins << (WIDTH - (1 << k)));
            end
        end
    end

    // Oversized amounts saturate to the fill word; rotate ignores the upper amount bits.
`ifdef RSHIFTER_ROTATE_EN
    assign w_result = (w_oversize && !w_rot) ? w_fill_word : w_shift;
`else
    assign w_result = w_oversize ? w_fill_word : w_shift;
`endif

    // Output register: load on accepted input, hold data otherwise; valid tracks In_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= In_valid;
            if (In_valid) begin
                r_out <= w_result;
            end
        end
    end

    assign Out       = r_out;
    assign Out_valid = r_out_valid;

endmodule

// File: tb/tb_rshifter32_unit.sv
// Self-checking bench for rshifter32_unit (WIDTH=32); honours RSHIFTER_ROTATE_EN.
module tb_rshifter32_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [1:0]  Mode;
    logic        In_valid;
    logic [31:0] Out;
    logic        Out_valid;

    int          n_tests;
    int          n_fail;
    logic [31:0] sb[$];
    logic [31:0] last_out;

    rshifter32_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In1       (In1),
        .In2       (In2),
        .Mode      (Mode),
        .In_valid  (In_valid),
        .Out       (Out),
        .Out_valid (Out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model written directly from the behavioural description.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m);
        int unsigned r;
        r = 0;
`ifdef RSHIFTER_ROTATE_EN
        if (m == 2'b10) begin
            r = 32'(b[4:0]);
            if (r == 0) return a;
            return (a >> r) | (a << (32 - r));
        end
`endif
        if (m == 2'b01) begin
            if (b >= 32) return {32{a[31]}};
            return 32'($signed(a) >>> b);
        end
        if (b >= 32) return 32'h0;
        return a >> b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, push expectation, sample #1 after the edge and compare.
    task automatic step(input string tag, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] m, input logic [31:0] exp);
        logic [31:0] e;
        In_valid = v;
        In1      = a;
        In2      = b;
        Mode     = m;
        if (v) sb.push_back(exp);
        @(posedge clk);
        #1;
        if (v) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            end else begin
                e        = sb.pop_front();
                last_out = e;
                check(tag, Out, e);
            end
            check({tag, "_valid"}, 32'(Out_valid), 32'd1);
        end else begin
            check({tag, "_hold"}, Out, last_out);
            check({tag, "_valid"}, 32'(Out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
        n_tests  = 0;
        n_fail   = 0;
        last_out = 32'h0;
        rst_n    = 1'b0;
        In_valid = 1'b0;
        In1      = 32'h0;
        In2      = 32'h0;
        Mode     = 2'b00;

        // Reset state
        #3;
        check("rst_out", Out, 32'h0);
        check("rst_valid", 32'(Out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_out", Out, 32'h0);
        rst_n = 1'b1;

        // Logical shifts
        step("lsr4", 1'b1, 32'hF000000F, 32'd4, 2'b00, 32'h0F000000);
        step("lsr0", 1'b1, 32'hF000000F, 32'd0, 2'b00, 32'hF000000F);
        // Arithmetic shifts
        step("asr31", 1'b1, 32'h80000000, 32'd31, 2'b01, 32'hFFFFFFFF);
        step("asr1_pos", 1'b1, 32'h40000000, 32'd1, 2'b01, 32'h20000000);
        step("asr0", 1'b1, 32'h80000001, 32'd0, 2'b01, 32'h80000001);
        // Oversized amounts
        step("lsr32", 1'b1, 32'hDEADBEEF, 32'd32, 2'b00, 32'h0);
        step("asr256", 1'b1, 32'hDEADBEEF, 32'h00000100, 2'b01, 32'hFFFFFFFF);
        step("asr40_pos", 1'b1, 32'h7FFFFFFF, 32'd40, 2'b01, 32'h0);
        step("lsr_big", 1'b1, 32'hFFFFFFFF, 32'h80000001, 2'b00, 32'h0);
        // Reserved mode behaves as logical
        step("mode11", 1'b1, 32'hF000000F, 32'd4, 2'b11, 32'h0F000000);
        // Back-to-back then idle
        step("b2b1", 1'b1, 32'h00000080, 32'd1, 2'b00, 32'h00000040);
        step("b2b2", 1'b1, 32'h00000080, 32'd2, 2'b00, 32'h00000020);
        step("b2b3", 1'b1, 32'h00000080, 32'd3, 2'b00, 32'h00000010);
        step("idle", 1'b0, 32'h12345678, 32'd5, 2'b00, 32'h0);
        step("idle2", 1'b0, 32'hFFFFFFFF, 32'd0, 2'b01, 32'h0);

        // Mode=10: rotate when enabled, otherwise logical
`ifdef RSHIFTER_ROTATE_EN
        step("rot1", 1'b1, 32'h00000001, 32'd1, 2'b10, 32'h80000000);
        step("rot33", 1'b1, 32'h00000001, 32'd33, 2'b10, 32'h80000000);
        step("rot32", 1'b1, 32'hDEADBEEF, 32'd32, 2'b10, 32'hDEADBEEF);
`else
        step("mode10_lsr1", 1'b1, 32'h00000001, 32'd1, 2'b10, 32'h0);
        step("mode10_lsr33", 1'b1, 32'h00000001, 32'd33, 2'b10, 32'h0);
        step("mode10_lsr4", 1'b1, 32'hF000000F, 32'd4, 2'b10, 32'h0F000000);
`endif

        // Reset mid-run with In_valid high: outputs clear immediately and hold
        step("pre_rst", 1'b1, 32'hCAFEF00D, 32'd8, 2'b00, 32'h00CAFEF0);
        In_valid = 1'b1;
        In1      = 32'h12345678;
        In2      = 32'd4;
        Mode     = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", Out, 32'h0);
        check("midrst_valid", 32'(Out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_hold_out", Out, 32'h0);
        check("midrst_hold_valid", 32'(Out_valid), 32'd0);
        sb.delete();
        last_out = 32'h0;
        #2;
        rst_n = 1'b1;
        step("post_rst", 1'b1, 32'h12345678, 32'd4, 2'b00, 32'h01234567);
        step("post_rst_idle", 1'b0, 32'h0, 32'd0, 2'b00, 32'h0);

        // Random sweep against the model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 5 == 0) ? $urandom : 32'($urandom_range(0, 40));
            m = 2'($urandom_range(0, 3));
            step("rand", 1'b1, a, b, m, model(a, b, m));
        end
        step("final_idle", 1'b0, 32'h0, 32'd0, 2'b00, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rshifter32_unit.md
Name: rshifter32_unit

Overview:
- Registered 32-bit right-shift unit for the ALU32 datapath.
- Shifts operand In1 right by the amount in In2 (logical or arithmetic) and presents the result one clock later on Out.
- Sits alongside the other ALU32 function units; the ALU result mux selects Out.
- Implemented as a 5-stage combinational barrel shifter feeding an output register.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, at least 2. Shift-index width is SW = log2(WIDTH), which is 5 at the default.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- In1  input  WIDTH  operand to be shifted.
- In2  input  WIDTH  shift amount, unsigned, full width is significant.
- Mode  input  2  00 = logical right, 01 = arithmetic right, 10 = rotate right (only with the optional feature), 11 = reserved.
- In_valid  input  1  In1/In2/Mode are sampled on a clock edge where this is high.
- Out  output  WIDTH  registered shift result.
- Out_valid  output  1  high for exactly the cycle after an accepted input.

Behaviour:
- Reset:
  - Asserting rst_n low clears Out to 0 and Out_valid to 0 immediately, without waiting for a clock edge.
  - Both outputs hold those values while rst_n is low.
  - The first capture after reset is the first rising edge at which rst_n is high and In_valid is 1.
- Latency and handshake:
  - Latency is exactly 1 clock.
  - On a rising edge with In_valid=1, Out is loaded with shift(In1, In2, Mode) and Out_valid is set to 1.
  - On a rising edge with In_valid=0, Out holds its previous value and Out_valid is set to 0.
  - There is no backpressure; one result can be accepted every cycle (full throughput).
- Logical shift (Mode=00):
  - Out = In1 >> In2, with zeros shifted into the MSBs.
  - If In2 >= WIDTH (any bit above SW-1 set, or the value equals or exceeds WIDTH), Out = 0.
- Arithmetic shift (Mode=01):
  - Copies of In1[WIDTH-1] are shifted into the MSBs.
  - If In2 >= WIDTH, Out = all bits equal to In1[WIDTH-1].
- Shift amount 0: Out = In1 in every mode.
- Barrel structure:
  - Stage k (k = 0..SW-1) shifts by 2^k when In2[k] is 1.
  - Fill bits are zero for logical mode and the sign bit for arithmetic mode.
  - The In2 >= WIDTH override is applied after the final stage.
- Mode=11, and Mode=10 when the optional feature is compiled out: behave exactly as Mode=00.
- Out_valid does not depend on Mode.
- Reset mid-operation: an accepted input whose result has not yet been registered is discarded; no stale result appears after reset is released.

Optional Feature:
- Macro: RSHIFTER_ROTATE_EN.
- Defined:
  - Mode=10 performs rotate right by In2[SW-1:0]; In2 bits above SW-1 are ignored.
  - Bits shifted out of the LSB re-enter at the MSB.
  - Rotate by 0, or by any multiple of WIDTH, returns In1 unchanged.
- Undefined:
  - No rotate logic is generated.
  - Mode=10 is treated as logical shift (Mode=00).

Test Plan:
- Reset and hold: drive rst_n low mid-run with In_valid=1 -> Out=0x00000000 and Out_valid=0 immediately and while low; the first result appears one edge after release with In_valid=1.
- Logical shift: In1=0xF000000F, In2=4, Mode=00 -> Out=0x0F000000 on the next cycle with Out_valid=1.
  - Same In1 with In2=0 -> Out=0xF000000F.
- Arithmetic shift:
  - In1=0x80000000, In2=31, Mode=01 -> Out=0xFFFFFFFF.
  - In1=0x40000000, In2=1, Mode=01 -> Out=0x20000000.
- Oversized amount:
  - In1=0xDEADBEEF, In2=32, Mode=00 -> Out=0.
  - Same In1, In2=0x00000100, Mode=01 -> Out=0xFFFFFFFF.
  - In1=0x7FFFFFFF, In2=40, Mode=01 -> Out=0.
- Throughput and valid gating:
  - Back-to-back inputs (In2=1,2,3 on In1=0x80) -> Out=0x40, 0x20, 0x10 on consecutive cycles with Out_valid=1.
  - A following cycle with In_valid=0 -> Out holds 0x10 and Out_valid=0.
- Rotate with the macro defined: In1=0x00000001, In2=1, Mode=10 -> Out=0x80000000; In2=33 -> Out=0x80000000.
  - Without the macro, the same In2=1 stimulus -> Out=0.
